// File: rtl/hazard_pkg.sv
// hazard_pkg: shared record type, forwarding encodings and hazard helper functions
package hazard_pkg;
  localparam int REG_AW = 5;
  localparam int REG_TW = 2;
  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_W = 2'd1;
  localparam logic [1:0] FWD_M = 2'd2;
  localparam logic [1:0] FWD_E = 2'd3;
  localparam logic [REG_TW-1:0] TUSE_NONE = 2'd3;
  typedef struct packed {
    logic [REG_AW-1:0] a3;
    logic [REG_TW-1:0] tnew;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } hz_rec_t;
  localparam int REC_W = $bits(hz_rec_t);
  function automatic logic [REG_TW-1:0] sat_dec(input logic [REG_TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction
  function automatic logic hit(input hz_rec_t x, input logic [REG_AW-1:0] r);
    return (r != '0) && (x.a3 == r);
  endfunction
  function automatic logic ready(input hz_rec_t x, input logic [REG_AW-1:0] r);
    return hit(x, r) && (x.tnew == '0);
  endfunction
  function automatic logic late(input hz_rec_t x, input logic [REG_AW-1:0] r,
                                input logic [REG_TW-1:0] tuse);
    return hit(x, r) && (tuse < x.tnew);
  endfunction
  // A younger match that is not ready yet shadows older stages so stale data never wins
  function automatic logic [1:0] sel_d(input hz_rec_t e, input hz_rec_t m, input hz_rec_t w,
                                       input logic [REG_AW-1:0] r);
    return hit(e, r) ? (ready(e, r) ? FWD_E : FWD_GRF) :
           hit(m, r) ? (ready(m, r) ? FWD_M : FWD_GRF) :
           ready(w, r) ? FWD_W : FWD_GRF;
  endfunction
  function automatic logic [1:0] sel_e(input hz_rec_t m, input hz_rec_t w,
                                       input logic [REG_AW-1:0] r);
    return hit(m, r) ? (ready(m, r) ? FWD_M : FWD_GRF) :
           ready(w, r) ? FWD_W : FWD_GRF;
  endfunction
endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one shadow-pipeline record with bubble insert and optional tnew countdown
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter bit DEC = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [REC_W-1:0] d,
  output logic [REC_W-1:0] q
);
  hz_rec_t nxt;
  always_comb begin
    nxt = hz_rec_t'(d);
    nxt.tnew = DEC ? sat_dec(nxt.tnew) : nxt.tnew;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else q <= load ? REC_W'(nxt) : '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: Tnew/Tuse stall detection and forwarding selects for the 5-stage pipeline
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int AW = REG_AW,
  parameter int TW = REG_TW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [TW-1:0] d_tnew,
  input  logic [AW-1:0] d_a3,
  output logic          stall,
  output logic [1:0]    fwd_d_rs,
  output logic [1:0]    fwd_d_rt,
  output logic [1:0]    fwd_e_rs,
  output logic [1:0]    fwd_e_rt,
  output logic          fwd_m_rt
);
  hz_rec_t e_q, m_q, w_q;
  hazard_stage_reg #(.DEC(1'b0)) u_e (
    .clk(clk), .reset(reset), .load(!stall), .d({d_a3, d_tnew, d_rs, d_rt}), .q(e_q)
  );
  hazard_stage_reg #(.DEC(1'b1)) u_m (
    .clk(clk), .reset(reset), .load(1'b1), .d(e_q), .q(m_q)
  );
  hazard_stage_reg #(.DEC(1'b1)) u_w (
    .clk(clk), .reset(reset), .load(1'b1), .d(m_q), .q(w_q)
  );
  always_comb begin
    stall = late(e_q, d_rs, d_tuse_rs) || late(m_q, d_rs, d_tuse_rs) ||
            late(e_q, d_rt, d_tuse_rt) || late(m_q, d_rt, d_tuse_rt);
    fwd_d_rs = sel_d(e_q, m_q, w_q, d_rs);
    fwd_d_rt = sel_d(e_q, m_q, w_q, d_rt);
    fwd_e_rs = sel_e(m_q, w_q, e_q.rs);
    fwd_e_rt = sel_e(m_q, w_q, e_q.rt);
    fwd_m_rt = ready(w_q, m_q.rt);
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenario checks for hazard_ctrl
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] d_rs = '0, d_rt = '0, d_a3 = '0;
  logic [1:0] d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0;
  logic       stall, fwd_m_rt;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  int checks = 0, failures = 0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs),
    .d_tuse_rt(d_tuse_rt), .d_tnew(d_tnew), .d_a3(d_a3), .stall(stall),
    .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs),
    .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] rs, input logic [1:0] tur, input logic [4:0] rt,
                       input logic [1:0] tut, input logic [1:0] tn, input logic [4:0] a3);
    d_rs = rs; d_tuse_rs = tur; d_rt = rt; d_tuse_rt = tut; d_tnew = tn; d_a3 = a3;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 2'd0, 5'd0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt});
    end
    checks++;
    if ({dut.e_q, dut.m_q, dut.w_q} !== '0) begin
      failures++;
      $display("FAIL reset_records got=%h exp=0", {dut.e_q, dut.m_q, dut.w_q});
    end
    reset = 1'b0;
  endtask

  task automatic test_no_hazard();
    flush();
    drive(5'd2, 2'd1, 5'd3, 2'd1, 2'd1, 5'd1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt} !== 10'b0) begin
        failures++;
        $display("FAIL no_hazard cyc=%0d got=%b exp=0", i, {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt});
      end
      tick();
      if (i == 0) drive(5'd6, 2'd1, 5'd0, 2'd3, 2'd1, 5'd5);
      else drive(5'd0, 2'd3, 5'd0, 2'd3, 2'd0, 5'd0);
    end
  endtask

  task automatic test_lw_beq();
    flush();
    drive(5'd29, 2'd1, 5'd0, 2'd3, 2'd2, 5'd8);
    tick();
    drive(5'd8, 2'd0, 5'd9, 2'd0, 2'd0, 5'd0);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL lw_stall1 got=%b exp=1", stall); end
    checks++;
    if (fwd_d_rs !== 2'd0) begin failures++; $display("FAIL lw_sel_grf got=%0d exp=0", fwd_d_rs); end
    tick();
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL lw_stall2 got=%b exp=1", stall); end
    checks++;
    if (dut.e_q !== '0) begin failures++; $display("FAIL lw_bubble1 got=%h exp=0", dut.e_q); end
    tick();
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL lw_release got=%b exp=0", stall); end
    checks++;
    if (fwd_d_rs !== 2'd1) begin failures++; $display("FAIL lw_fwd_w got=%0d exp=1", fwd_d_rs); end
    checks++;
    if (dut.e_q !== '0) begin failures++; $display("FAIL lw_bubble2 got=%h exp=0", dut.e_q); end
    tick();
    checks++;
    if (dut.e_q.rs !== 5'd8) begin failures++; $display("FAIL lw_beq_enters_e got=%0d exp=8", dut.e_q.rs); end
  endtask

  task automatic test_fwd_store();
    flush();
    drive(5'd2, 2'd1, 5'd3, 2'd1, 2'd1, 5'd4);
    tick();
    drive(5'd29, 2'd1, 5'd4, 2'd2, 2'd0, 5'd0);
    checks++;
    if ({stall, fwd_d_rt} !== 3'b000) begin failures++; $display("FAIL sw_d got=%b exp=000", {stall, fwd_d_rt}); end
    tick();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 2'd0, 5'd0);
    checks++;
    if ({fwd_e_rt, fwd_e_rs} !== 4'b1000) begin failures++; $display("FAIL sw_e got=%b exp=1000", {fwd_e_rt, fwd_e_rs}); end
    tick();
    checks++;
    if (fwd_m_rt !== 1'b1) begin failures++; $display("FAIL sw_m got=%b exp=1", fwd_m_rt); end
  endtask

  task automatic test_priority();
    flush();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 2'd0, 5'd9);
    tick();
    tick();
    drive(5'd9, 2'd0, 5'd9, 2'd0, 2'd0, 5'd0);
    checks++;
    if ({stall, fwd_d_rs, fwd_d_rt} !== 5'b01111) begin
      failures++; $display("FAIL prio_d got=%b exp=01111", {stall, fwd_d_rs, fwd_d_rt});
    end
    tick();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 2'd0, 5'd0);
    checks++;
    if ({fwd_e_rs, fwd_e_rt} !== 4'b1010) begin failures++; $display("FAIL prio_e got=%b exp=1010", {fwd_e_rs, fwd_e_rt}); end
    tick();
    checks++;
    if (fwd_m_rt !== 1'b1) begin failures++; $display("FAIL prio_m got=%b exp=1", fwd_m_rt); end
  endtask

  task automatic test_block();
    flush();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 2'd0, 5'd9);
    tick();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 2'd1, 5'd9);
    tick();
    drive(5'd9, 2'd1, 5'd0, 2'd3, 2'd0, 5'd0);
    checks++;
    if ({stall, fwd_d_rs} !== 3'b000) begin failures++; $display("FAIL block_d got=%b exp=000", {stall, fwd_d_rs}); end
  endtask

  task automatic test_zero();
    flush();
    drive(5'd1, 2'd3, 5'd0, 2'd3, 2'd2, 5'd0);
    tick();
    drive(5'd0, 2'd0, 5'd0, 2'd0, 2'd0, 5'd0);
    checks++;
    if ({stall, fwd_d_rs, fwd_d_rt} !== 5'b0) begin failures++; $display("FAIL zero_reg got=%b exp=0", {stall, fwd_d_rs, fwd_d_rt}); end
  endtask

  task automatic test_async_reset();
    flush();
    drive(5'd29, 2'd1, 5'd0, 2'd3, 2'd2, 5'd8);
    tick();
    drive(5'd8, 2'd0, 5'd9, 2'd0, 2'd0, 5'd0);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b exp=1", stall); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL arst_stall got=%b exp=0", stall); end
    tick();
    checks++;
    if ({dut.e_q, dut.m_q, dut.w_q} !== '0) begin failures++; $display("FAIL arst_records got=%h exp=0", {dut.e_q, dut.m_q, dut.w_q}); end
    reset = 1'b0;
    tick();
    checks++;
    if (dut.e_q.rs !== 5'd8 || dut.m_q !== '0) begin
      failures++; $display("FAIL arst_resume got=%0d/%h exp=8/0", dut.e_q.rs, dut.m_q);
    end
  endtask

  initial begin
    test_reset();
    test_no_hazard();
    test_lw_beq();
    test_fwd_store();
    test_priority();
    test_block();
    test_zero();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Consumer of the per-instruction Tnew/Tuse codes produced by the decode-side timing generator in the 5-stage MIPS pipeline (F/D/E/M/W).
- Keeps a shadow pipeline of {A3, Tnew, rs, rt} records for E, M and W.
- Each cycle it compares these records against D-stage Tuse demands and outputs the stall signal plus all forwarding-mux selects.
- Sits beside the datapath. It drives the D-hold, the E bubble insert and the forwarding muxes.

Parameters:
- AW, 5, register-address width.
- TW, 2, width of Tnew/Tuse codes.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all shadow records.
- d_rs  in  AW  rs field of the instruction in D.
- d_rt  in  AW  rt field of the instruction in D.
- d_tuse_rs  in  TW  Tuse for rs; 3 = operand unused.
- d_tuse_rt  in  TW  Tuse for rt; 3 = operand unused.
- d_tnew  in  TW  Tnew of the D instruction, measured from E entry.
- d_a3  in  AW  destination register of the D instruction; 0 = no write.
- stall  out  1  freeze PC and F/D register; insert bubble into D/E.
- fwd_d_rs  out  2  D-stage rs source: 0 GRF, 1 W, 2 M, 3 E.
- fwd_d_rt  out  2  D-stage rt source; same encoding as fwd_d_rs.
- fwd_e_rs  out  2  E-stage rs source: 0 pipe reg, 1 W, 2 M.
- fwd_e_rt  out  2  E-stage rt source; same encoding as fwd_e_rs.
- fwd_m_rt  out  1  M-stage rt (store data) source: 0 pipe reg, 1 W.

Behaviour:
- Shadow records: E_rec, M_rec, W_rec. Each holds {a3, tnew, rs, rt}. Reset value is all zero, which is a bubble.
- Tnew is a remaining-cycle count:
  - E_rec.tnew = d_tnew latched at E entry.
  - On advance, M_rec.tnew = E_rec.tnew - 1, saturating at 0.
  - W_rec.tnew = M_rec.tnew - 1, saturating at 0. It is always 0 in practice.
- Every rising clk edge:
  - W_rec <= M_rec and M_rec <= E_rec, unconditionally.
  - If stall = 0: E_rec <= {d_a3, d_tnew, d_rs, d_rt}.
  - If stall = 1: E_rec <= 0 (bubble).
- Matching rule: match(X, r) = (r != 0) && (X.a3 == r).
- stall is combinational and is asserted if any of the following holds:
  - match(E_rec, d_rs) && d_tuse_rs < E_rec.tnew
  - match(M_rec, d_rs) && d_tuse_rs < M_rec.tnew
  - the same two terms for d_rt with d_tuse_rt.
- Tuse = 3 never stalls, because Tnew <= 2.
- D forwarding:
  - Priority: E, then M, then W.
  - A stage qualifies only if match && its tnew == 0.
  - If no stage qualifies, the select is GRF (0).
  - A match whose tnew is nonzero blocks lower-priority stages. The stall covers that case; the select value is then don't-care but must be deterministic (GRF).
- E forwarding:
  - Uses E_rec.rs / E_rec.rt against M_rec, then W_rec.
  - Same tnew == 0 qualification.
- M forwarding: M_rec.rt against W_rec.
- Register $0 never forwards and never stalls.
- Latency: stall and all selects are purely combinational from inputs and current records, so they are valid in the same cycle. Records update with one-cycle latency.
- Simultaneous events: while a stall is asserted, M and W still drain. A stall resolves after at most 2 cycles (lw followed by a Tuse=0 consumer).
- Reset asserted mid-stall: all records clear immediately (async), so stall deasserts in the same cycle.
- Reset must be deasserted synchronously to clk by the system.

Decomposition:
- hazard_pkg holds:
  - FWD_GRF/FWD_W/FWD_M/FWD_E encodings
  - TUSE_NONE = 3
  - the record struct {a3, tnew, rs, rt}
  - the saturating-decrement function
- One sub-module, hazard_stage_reg: a record register with async reset, a load/bubble select and a tnew decrement on output. It is instantiated three times.

Test Plan:
- Hazard-free sequence. `addu $1,$2,$3` followed by an unrelated `ori $5,$6,1` -> stall = 0 every cycle; all selects 0.
- lw followed by beq. E_rec = {a3=8, tnew=2} with d_rs = 8, d_tuse_rs = 0:
  - stall = 1 for 2 cycles;
  - the next cycle has fwd_d_rs = 1 (W);
  - E_rec is a bubble on both stalled cycles.
- addu followed by sw on rt.
  - Setup: E_rec = {a3=4, tnew=1}, d_rt = 4, d_tuse_rt = 2.
  - Expected: no stall. When sw reaches E, fwd_e_rt = 2 (M). When sw reaches M, fwd_m_rt = 1.
- Priority. E_rec and M_rec both write $9 with tnew = 0; d_rs = 9, tuse = 0 -> fwd_d_rs = 3 (E).
- $0 guard. E_rec.a3 = 0 with tnew = 2 and d_rs = 0 -> stall = 0, fwd_d_rs = 0.
- Async reset pulse during an lw stall -> stall drops immediately; all records read zero on the next edge.
